// File: rtl/lcd_panel_model.sv
// Responder for the two-chip 128x64 graphic LCD bus: decodes driver commits,
// keeps a per-chip display RAM image and offers a registered readback port.
module lcd_panel_model #(
    parameter int unsigned RAM_AW      = 10,
    parameter bit          STATUS_BUSY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        db_i,
    input  logic              dori_i,
    input  logic [1:0]        cs_i,
    input  logic              en_i,
    input  logic              rw_i,
    input  logic              rst_i,
    output logic [7:0]        db_o,
    output logic              db_oe_o,
    input  logic [RAM_AW-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic [1:0]        on_o,
    output logic [5:0]        start0_o,
    output logic [5:0]        start1_o,
    output logic              err_o
);
    localparam int unsigned BANK_AW = RAM_AW - 1;
    localparam int unsigned DEPTH   = 1 << BANK_AW;

    typedef enum logic [2:0] {
        OP_DISPLAY,
        OP_SET_Y,
        OP_SET_PAGE,
        OP_SET_START,
        OP_UNDEF
    } op_e;

    // One bank per chip so a broadcast data write lands in both in one cycle.
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];

    logic               en_q;
    logic [7:0]         db_sh_q;
    logic               dori_sh_q;
    logic [1:0]         cs_sh_q;
    logic               rw_sh_q;
    logic [5:0]         y_q     [2];
    logic [5:0]         y_d     [2];
    logic [2:0]         page_q  [2];
    logic [2:0]         page_d  [2];
    logic [5:0]         start_q [2];
    logic [5:0]         start_d [2];
    logic [1:0]         on_q, on_d;
    logic               err_q, err_d;
    logic [7:0]         rd_data_q;

    logic               commit;
    op_e                op;
    logic [1:0]         we;
    logic               sel_sh, sel_live;
    logic [BANK_AW-1:0] waddr [2];
    logic [7:0]         rd_bus, status;

    always_comb begin
        op = OP_UNDEF;
        if (db_sh_q[7:1] == 7'b0011_111)      op = OP_DISPLAY;
        else if (db_sh_q[7:6] == 2'b01)       op = OP_SET_Y;
        else if (db_sh_q[7:3] == 5'b1011_1)   op = OP_SET_PAGE;
        else if (db_sh_q[7:6] == 2'b11)       op = OP_SET_START;
    end

    always_comb begin
        commit = en_q & ~en_i & ~rst & ~rst_i;
        sel_sh = ~cs_sh_q[0] & cs_sh_q[1];
        on_d   = on_q;
        err_d  = 1'b0;
        we     = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            y_d[c]     = y_q[c];
            page_d[c]  = page_q[c];
            start_d[c] = start_q[c];
            waddr[c]   = {page_q[c], y_q[c]};
        end
        if (rst_i) begin
            on_d = '0;
            for (int unsigned c = 0; c < 2; c++) begin
                y_d[c]     = '0;
                page_d[c]  = '0;
                start_d[c] = '0;
            end
        end else if (commit) begin
            case ({dori_sh_q, rw_sh_q})
                2'b00: begin
                    err_d = (op == OP_UNDEF) && (cs_sh_q != 2'b00);
                    for (int unsigned c = 0; c < 2; c++) begin
                        if (cs_sh_q[c]) begin
                            case (op)
                                OP_DISPLAY:   on_d[c]    = db_sh_q[0];
                                OP_SET_Y:     y_d[c]     = db_sh_q[5:0];
                                OP_SET_PAGE:  page_d[c]  = db_sh_q[2:0];
                                OP_SET_START: start_d[c] = db_sh_q[5:0];
                                default: ;
                            endcase
                        end
                    end
                end
                2'b10: begin
                    for (int unsigned c = 0; c < 2; c++) begin
                        if (cs_sh_q[c]) begin
                            we[c]  = 1'b1;
                            y_d[c] = y_q[c] + 6'd1;
                        end
                    end
                end
                2'b11: begin
                    if (cs_sh_q != 2'b00) y_d[sel_sh] = y_q[sel_sh] + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus read presentation follows the live strobe, not the shadow copy.
    always_comb begin
        sel_live = ~cs_i[0] & cs_i[1];
        rd_bus   = sel_live ? mem1[{page_q[1], y_q[1]}] : mem0[{page_q[0], y_q[0]}];
        status   = {STATUS_BUSY, 1'b0, ~(on_q[sel_live] & ~rst_i), rst_i, 4'b0000};
        db_oe_o  = en_i & rw_i & ~rst;
        db_o     = '0;
        if (db_oe_o) db_o = dori_i ? rd_bus : status;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            db_sh_q   <= '0;
            dori_sh_q <= 1'b0;
            cs_sh_q   <= '0;
            rw_sh_q   <= 1'b0;
            on_q      <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            for (int unsigned c = 0; c < 2; c++) begin
                y_q[c]     <= '0;
                page_q[c]  <= '0;
                start_q[c] <= '0;
            end
        end else begin
            en_q <= en_i;
            if (en_i) begin
                db_sh_q   <= db_i;
                dori_sh_q <= dori_i;
                cs_sh_q   <= cs_i;
                rw_sh_q   <= rw_i;
            end
            on_q      <= on_d;
            err_q     <= err_d;
            rd_data_q <= rd_addr_i[RAM_AW-1] ? mem1[rd_addr_i[BANK_AW-1:0]]
                                             : mem0[rd_addr_i[BANK_AW-1:0]];
            for (int unsigned c = 0; c < 2; c++) begin
                y_q[c]     <= y_d[c];
                page_q[c]  <= page_d[c];
                start_q[c] <= start_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we[0]) mem0[waddr[0]] <= db_sh_q;
        if (we[1]) mem1[waddr[1]] <= db_sh_q;
    end

    assign on_o      = on_q;
    assign start0_o  = start_q[0];
    assign start1_o  = start_q[1];
    assign err_o     = err_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Randomized bench for lcd_panel_model against a flat-array panel model.
module tb_lcd_panel_model;
    logic       clk = 1'b0;
    logic       rst, dori_i, en_i, rw_i, rst_i;
    logic [7:0] db_i, db_o, rd_data_o;
    logic [1:0] cs_i, on_o;
    logic       db_oe_o, err_o;
    logic [9:0] rd_addr_i;
    logic [5:0] start0_o, start1_o;

    always #5 clk = ~clk;

    lcd_panel_model #(.RAM_AW(10), .STATUS_BUSY(1'b0)) dut (
        .clk(clk), .rst(rst), .db_i(db_i), .dori_i(dori_i), .cs_i(cs_i),
        .en_i(en_i), .rw_i(rw_i), .rst_i(rst_i), .db_o(db_o), .db_oe_o(db_oe_o),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .on_o(on_o),
        .start0_o(start0_o), .start1_o(start1_o), .err_o(err_o)
    );

    int unsigned n_vec = 0, n_miss = 0;
    int  ref_mem [1024];
    bit  ref_ok  [1024];
    int  ref_y [2], ref_pg [2], ref_st [2];
    bit  ref_on [2];
    bit  exp_err = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sel_of(input logic [1:0] cs);
        return (cs == 2'b10) ? 1 : 0;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 2; c++) begin
            ref_y[c] = 0; ref_pg[c] = 0; ref_st[c] = 0; ref_on[c] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_val("err_o", 32'(err_o), 32'(exp_err));
        exp_err = 1'b0;
        check_val("on_o", 32'(on_o), 32'({ref_on[1], ref_on[0]}));
        check_val("start0", 32'(start0_o), 32'(ref_st[0]));
        check_val("start1", 32'(start1_o), 32'(ref_st[1]));
    endtask

    task automatic model_commit(input logic [1:0] cs, input logic d, input logic rw, input logic [7:0] data);
        int dv, a, s;
        dv = int'(data);
        if (rst_i || cs == 2'b00) return;
        if (!d && !rw) begin
            if      ((dv >> 1) == 'h1F) begin for (int c = 0; c < 2; c++) if (cs[c]) ref_on[c] = dv[0]; end
            else if ((dv >> 6) == 1)    begin for (int c = 0; c < 2; c++) if (cs[c]) ref_y[c]  = dv % 64; end
            else if ((dv >> 3) == 'h17) begin for (int c = 0; c < 2; c++) if (cs[c]) ref_pg[c] = dv % 8; end
            else if ((dv >> 6) == 3)    begin for (int c = 0; c < 2; c++) if (cs[c]) ref_st[c] = dv % 64; end
            else exp_err = 1'b1;
        end else if (d && !rw) begin
            for (int c = 0; c < 2; c++) begin
                if (cs[c]) begin
                    a = c * 512 + ref_pg[c] * 64 + ref_y[c];
                    ref_mem[a] = dv; ref_ok[a] = 1'b1;
                    ref_y[c] = (ref_y[c] + 1) % 64;
                end
            end
        end else if (d && rw) begin
            s = sel_of(cs);
            ref_y[s] = (ref_y[s] + 1) % 64;
        end
    endtask

    task automatic xfer(input logic [1:0] cs, input logic d, input logic rw, input logic [7:0] data);
        int s, a;
        logic [7:0] exp_rd;
        a = 0;
        step();
        cs_i = cs; dori_i = d; rw_i = rw; db_i = data; en_i = 1'b1;
        s = sel_of(cs);
        if (d) begin
            a = s * 512 + ref_pg[s] * 64 + ref_y[s];
            exp_rd = 8'(ref_mem[a]);
        end else begin
            exp_rd = (ref_on[s] ? 8'h00 : 8'h20) | (rst_i ? 8'h10 : 8'h00);
        end
        #1;
        check_val("db_oe", 32'(db_oe_o), 32'(rw));
        if (rw && (!d || ref_ok[a])) check_val("db_o", 32'(db_o), 32'(exp_rd));
        step();
        en_i = 1'b0;
        db_i = 8'($urandom); dori_i = 1'($urandom); cs_i = 2'($urandom); rw_i = 1'($urandom);
        model_commit(cs, d, rw, data);
    endtask

    task automatic readback(input int addr);
        step();
        rd_addr_i = 10'(addr);
        step();
        if (ref_ok[addr]) check_val("rdback", 32'(rd_data_o), 32'(ref_mem[addr]));
    endtask

    task automatic panel_reset(input int n);
        step();
        rst_i = 1'b1;
        clear_model();
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [1:0] rcs;
        logic [7:0] rdat;
        int a;
        rst = 1'b1; rst_i = 1'b0; en_i = 1'b0; rw_i = 1'b0; dori_i = 1'b0;
        cs_i = 2'b00; db_i = 8'h00; rd_addr_i = '0;
        clear_model();
        repeat (3) step();
        check_val("rst_db_o", 32'(db_o), 0);
        check_val("rst_db_oe", 32'(db_oe_o), 0);
        check_val("rst_rd_data", 32'(rd_data_o), 0);
        rst = 1'b0;

        xfer(2'b01, 1'b0, 1'b0, 8'h3F);
        xfer(2'b01, 1'b0, 1'b0, 8'hB8);
        xfer(2'b01, 1'b0, 1'b0, 8'h40);
        step();
        check_val("cs1_on", 32'(on_o), 32'h1);

        xfer(2'b10, 1'b0, 1'b0, 8'hBB);
        xfer(2'b10, 1'b0, 1'b0, 8'h7E);
        xfer(2'b10, 1'b1, 1'b0, 8'hA5);
        readback(10'b1_011_111110);
        check_val("cs2_A5", 32'(rd_data_o), 32'hA5);
        xfer(2'b10, 1'b1, 1'b0, 8'h5A);
        xfer(2'b10, 1'b1, 1'b0, 8'h11);
        readback(10'b1_011_111111);
        check_val("cs2_5A", 32'(rd_data_o), 32'h5A);
        readback(10'b1_011_000000);

        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 8; p++) begin
                xfer(2'(1 << c), 1'b0, 1'b0, 8'hB8 | 8'(p));
                xfer(2'(1 << c), 1'b0, 1'b0, 8'h40);
                for (int col = 0; col < 64; col++)
                    xfer(2'(1 << c), 1'b1, 1'b0, 8'(c * 512 + p * 64 + col));
            end
        end
        for (int i = 0; i < 1024; i++) readback(i);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                6, 7, 8: readback(int'($urandom_range(0, 1023)));
                9: panel_reset(2);
                default: begin
                    rcs = 2'($urandom);
                    case ($urandom_range(0, 4))
                        0: rdat = 8'h3E | 8'($urandom_range(0, 1));
                        1: rdat = 8'h40 | 8'($urandom_range(0, 63));
                        2: rdat = 8'hB8 | 8'($urandom_range(0, 7));
                        3: rdat = 8'hC0 | 8'($urandom_range(0, 63));
                        default: rdat = 8'($urandom);
                    endcase
                    xfer(rcs, 1'($urandom), 1'($urandom), rdat);
                end
            endcase
        end

        xfer(2'b01, 1'b0, 1'b0, 8'h3E);
        xfer(2'b01, 1'b0, 1'b1, 8'h00);
        step();
        rst_i = 1'b1;
        clear_model();
        xfer(2'b01, 1'b0, 1'b1, 8'h00);
        step();
        rst_i = 1'b0;

        xfer(2'b01, 1'b0, 1'b0, 8'h3F);
        xfer(2'b01, 1'b0, 1'b0, 8'hBB);
        xfer(2'b01, 1'b0, 1'b0, 8'h49);
        xfer(2'b01, 1'b0, 1'b0, 8'h00);
        xfer(2'b01, 1'b1, 1'b0, 8'hC3);
        readback(3 * 64 + 9);
        check_val("undef_keep", 32'(rd_data_o), 32'hC3);

        xfer(2'b01, 1'b0, 1'b0, 8'hBD);
        xfer(2'b01, 1'b0, 1'b0, 8'h4A);
        xfer(2'b01, 1'b1, 1'b0, 8'h77);
        panel_reset(3);
        xfer(2'b01, 1'b1, 1'b0, 8'h99);
        readback(0);
        check_val("prst_col0", 32'(rd_data_o), 32'h99);
        readback(5 * 64 + 10);

        xfer(2'b01, 1'b0, 1'b0, 8'hBA);
        xfer(2'b01, 1'b0, 1'b0, 8'h45);
        a = 2 * 64 + 5;
        step();
        cs_i = 2'b01; dori_i = 1'b1; rw_i = 1'b0; db_i = 8'hEE; en_i = 1'b1;
        step();
        en_i = 1'b0; rst = 1'b1;
        clear_model();
        step();
        step();
        rst = 1'b0;
        readback(a);
        step();
        cs_i = 2'b01; dori_i = 1'b1; rw_i = 1'b0; db_i = 8'hEE; en_i = 1'b1; rst = 1'b1;
        step();
        en_i = 1'b0; rst = 1'b0;
        readback(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
